seg_scan: RTL and testbench

SEG_SCAN -- requirements
Module: seg_scan

---
 rtl/seg_scan.sv | 163 ++++++++++++++++
 tb/tb_seg_scan.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/seg_scan.sv
// seg_scan -- time-multiplexed driver for an 8-digit, common-anode,
// 7-segment display with frame-synchronous shadow loading.
//
// Ports
//   CLK       rising-edge clock
//   RST       asynchronous active-low reset
//   DIGITS    32-bit hex value, nibble i drives digit i
//   DIG_EN    per-digit enable (cleared bit blanks that digit)
//   DP        per-digit decimal point
//   LOAD      request to copy DIGITS/DIG_EN/DP into the shadow set
//   LOAD_ACK  one-cycle pulse, the cycle after the shadow copy
//   FRAME     one-cycle pulse on the last cycle of digit 7's slot
//   CA        active-low cathodes {dp, g..a}, registered
//   AN        active-low one-hot anodes, registered
//
// Build option
//   SEG_DEADTIME_EN  blank the first DEAD_CYCLES cycles of every slot
//                    (anti-ghosting). Undefined: no blanking, and
//                    DEAD_CYCLES is only range-checked.

// Per-digit hex-to-segment decoder (active-low).
module seg_scan_dec (
  input  logic [3:0] nib,
  input  logic       dp,
  output logic [7:0] ca
);
  always_comb begin
    ca = 8'hFF;
    case (nib)
      4'h0: ca[6:0] = 7'h40;
      4'h1: ca[6:0] = 7'h79;
      4'h2: ca[6:0] = 7'h24;
      4'h3: ca[6:0] = 7'h30;
      4'h4: ca[6:0] = 7'h19;
      4'h5: ca[6:0] = 7'h12;
      4'h6: ca[6:0] = 7'h02;
      4'h7: ca[6:0] = 7'h78;
      4'h8: ca[6:0] = 7'h00;
      4'h9: ca[6:0] = 7'h10;
      4'hA: ca[6:0] = 7'h08;
      4'hB: ca[6:0] = 7'h03;
      4'hC: ca[6:0] = 7'h46;
      4'hD: ca[6:0] = 7'h21;
      4'hE: ca[6:0] = 7'h06;
      4'hF: ca[6:0] = 7'h0E;
      default: ca[6:0] = 7'h7F;
    endcase
    ca[7] = ~dp;
  end
endmodule

module seg_scan #(
  parameter int DIGIT_CYCLES = 10000,
  parameter int DEAD_CYCLES  = 100
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [31:0] DIGITS,
  input  logic [7:0]  DIG_EN,
  input  logic [7:0]  DP,
  input  logic        LOAD,
  output logic        LOAD_ACK,
  output logic        FRAME,
  output logic [7:0]  CA,
  output logic [7:0]  AN
);
  localparam int NUM_DIG = 8;
  localparam int CW      = $clog2(DIGIT_CYCLES);

  if (DIGIT_CYCLES < 2 || DIGIT_CYCLES > 65535) begin : g_bad_cycles
    $error("seg_scan: DIGIT_CYCLES out of range 2..65535");
  end
  if (DEAD_CYCLES < 1 || DEAD_CYCLES >= DIGIT_CYCLES) begin : g_bad_dead
    $error("seg_scan: DEAD_CYCLES out of range 1..DIGIT_CYCLES-1");
  end

  typedef struct packed {
    logic [31:0] digits;
    logic [7:0]  en;
    logic [7:0]  dp;
  } shadow_t;

  logic [CW-1:0] cnt;
  logic [2:0]    idx;
  logic          pending;
  shadow_t       shadow;

  logic slot_end, frame_end, load_now, dead;
  logic [NUM_DIG-1:0][7:0] seg_ca;
  logic [7:0] an_d, ca_d;

  assign slot_end  = (cnt == CW'(DIGIT_CYCLES - 1));
  assign frame_end = slot_end && (idx == 3'd7);
  // A LOAD arriving in the boundary cycle itself is honoured immediately,
  // so the request never waits a whole extra frame.
  assign load_now  = frame_end && (pending || LOAD);
  assign FRAME     = frame_end;

`ifdef SEG_DEADTIME_EN
  assign dead = (cnt < CW'(DEAD_CYCLES));
`else
  assign dead = 1'b0;
`endif

  // Scan position
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      cnt <= '0;
      idx <= '0;
    end else if (slot_end) begin
      cnt <= '0;
      idx <= idx + 3'd1;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  // Load handshake: shadow only changes at the frame boundary, so a frame
  // is always drawn from one consistent snapshot.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      pending  <= 1'b0;
      shadow   <= '0;
      LOAD_ACK <= 1'b0;
    end else begin
      LOAD_ACK <= load_now;
      if (frame_end)
        pending <= 1'b0;
      else if (LOAD)
        pending <= 1'b1;
      if (load_now)
        shadow <= '{digits: DIGITS, en: DIG_EN, dp: DP};
    end
  end

  for (genvar g = 0; g < NUM_DIG; g++) begin : g_dec
    seg_scan_dec u_dec (
      .nib (shadow.digits[4*g +: 4]),
      .dp  (shadow.dp[g]),
      .ca  (seg_ca[g])
    );
  end

  always_comb begin
    an_d = 8'hFF;
    ca_d = 8'hFF;
    if (shadow.en[idx] && !dead) begin
      an_d = ~(8'h01 << idx);
      ca_d = seg_ca[idx];
    end
  end

  // Registered drive: outputs trail idx/cnt by exactly one cycle.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      AN <= 8'hFF;
      CA <= 8'hFF;
    end else begin
      AN <= an_d;
      CA <= ca_d;
    end
  end
endmodule

// File: tb/tb_seg_scan.sv
module tb_seg_scan;
  localparam int DC   = 4;
  localparam int DEAD = 1;
  localparam int FR   = 8 * DC;
  localparam int MAXF = 512;
`ifdef SEG_DEADTIME_EN
  localparam bit DEAD_EN = 1'b1;
`else
  localparam bit DEAD_EN = 1'b0;
`endif

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic [31:0] DIGITS = '0;
  logic [7:0]  DIG_EN = '0;
  logic [7:0]  DP = '0;
  logic        LOAD = 1'b0;
  logic        LOAD_ACK, FRAME;
  logic [7:0]  CA, AN;

  always #5 CLK = ~CLK;

  seg_scan #(.DIGIT_CYCLES(DC), .DEAD_CYCLES(DEAD)) dut (
    .CLK(CLK), .RST(RST), .DIGITS(DIGITS), .DIG_EN(DIG_EN), .DP(DP),
    .LOAD(LOAD), .LOAD_ACK(LOAD_ACK), .FRAME(FRAME), .CA(CA), .AN(AN)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: n = rising edges since reset release; the shadow
  // set is kept per frame number, captured at the end of the prior frame.
  int          n;
  int          ack_n;
  bit          pend;
  logic [31:0] sh_dg [MAXF];
  logic [7:0]  sh_en [MAXF];
  logic [7:0]  sh_dp [MAXF];
  logic [7:0]  seg_tab [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (n=%0d)", tag, obs, exp, n);
    end
  endtask

  task automatic model_reset();
    n = 0; pend = 0; ack_n = -1;
    sh_dg[0] = '0; sh_en[0] = '0; sh_dp[0] = '0;
  endtask

  task automatic check_out();
    logic [7:0] ea, ec;
    int p, f, d, c;
    ea = 8'hFF; ec = 8'hFF;
    if (n > 0) begin
      p = n - 1; f = p / FR; d = (p / DC) % 8; c = p % DC;
      if (sh_en[f][d] && !(DEAD_EN && c < DEAD)) begin
        ea = ~(8'h01 << d);
        ec = seg_tab[sh_dg[f][4*d +: 4]];
        if (sh_dp[f][d]) ec[7] = 1'b0;
      end
    end
    chk("AN", AN, ea);
    chk("CA", CA, ec);
    chk("FRAME", FRAME, (n % FR) == FR - 1);
    chk("LOAD_ACK", LOAD_ACK, n == ack_n);
  endtask

  // One clock: check outputs, present inputs, advance the model.
  task automatic step(input bit ld);
    int f;
    check_out();
    LOAD = ld;
    if (ld) pend = 1;
    if ((n % FR) == FR - 1) begin
      f = n / FR;
      if (pend) begin
        sh_dg[f+1] = DIGITS; sh_en[f+1] = DIG_EN; sh_dp[f+1] = DP;
        ack_n = n + 1; pend = 0;
      end else begin
        sh_dg[f+1] = sh_dg[f]; sh_en[f+1] = sh_en[f]; sh_dp[f+1] = sh_dp[f];
      end
    end
    @(posedge CLK);
    n++;
    @(negedge CLK);
    LOAD = 1'b0;
  endtask

  task automatic run(input int k, input bit rnd, input int ldpct);
    repeat (k) begin
      if (rnd) begin
        DIGITS = $urandom; DIG_EN = 8'($urandom); DP = 8'($urandom);
      end
      step(ldpct > 0 && $urandom_range(0, 99) < ldpct);
    end
  endtask

  task automatic wait_ack();
    int g = 0;
    while (n != ack_n && g < 3 * FR) begin step(0); g++; end
    chk("ack_timeout", n == ack_n, 1);
  endtask

  // Asynchronous reset mid-cycle: outputs must drop with no clock edge.
  task automatic async_rst();
    #2 RST = 1'b0;
    #1;
    chk("rst_AN", AN, 8'hFF);
    chk("rst_CA", CA, 8'hFF);
    chk("rst_ACK", LOAD_ACK, 0);
    chk("rst_FRAME", FRAME, 0);
    @(posedge CLK);
    @(negedge CLK);
    RST = 1'b1;
    model_reset();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    model_reset();
    repeat (2) @(negedge CLK);
    check_out();
    RST = 1'b1;

    // Load/scan of 0..7
    DIGITS = 32'h76543210; DIG_EN = 8'hFF; DP = 8'h00;
    step(1);
    run(FR, 0, 0);
    run(2 * FR, 1, 0);            // input churn without LOAD is invisible

    // DP and enable masks
    DIGITS = 32'h76543210; DIG_EN = 8'hF0; DP = 8'h01;
    step(1);
    run(2 * FR, 0, 0);
    DIG_EN = 8'hFF;
    step(1);
    run(2 * FR, 0, 0);

    // Tearing: new value mid-frame, LOAD during digit 3
    DIGITS = 32'hFFFFFFFF;
    run(FR, 0, 0);
    while ((n % FR) != 3 * DC) step(0);
    step(1);
    run(2 * FR, 0, 0);

    // LOAD exactly on the boundary cycle
    DIGITS = 32'h89ABCDEF; DP = 8'hA5;
    while ((n % FR) != FR - 1) step(0);
    step(1);
    run(2 * FR, 0, 0);

    // Random traffic
    run(40 * FR, 1, 8);

    // Reset while LOAD_ACK is high and digit 7 is lit
    DIGITS = 32'h01234567; DIG_EN = 8'hFF; DP = 8'h80;
    step(1);
    wait_ack();
    step(1);
    wait_ack();
    chk("pre_rst_AN", AN, 8'h7F);
    async_rst();

    // Reset with a request pending: it must be discarded
    step(1);
    run(DC + 1, 0, 0);
    async_rst();
    run(3 * FR, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
